// File: rtl/seq_gen_pkg.sv
// Shared definitions for the parametrised serial sequence generator.
//   MODE_*   : values of the mode input (loop, one-shot, PRBS, reserved)
//   state_e  : FSM state encoding, also exported on the debug state port
package seq_gen_pkg;

  localparam logic [1:0] MODE_LOOP = 2'b00;
  localparam logic [1:0] MODE_ONE  = 2'b01;
  localparam logic [1:0] MODE_PRBS = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_lfsr.sv
// Fibonacci-style LFSR used as the PRBS source.
//   clk_i         : clock, rising edge
//   rst_ni        : synchronous active-low reset, loads RST_SEED (0 -> 1)
//   load_i        : latch seed_i as both the running state and the reference seed
//   seed_i        : new seed; an all-zero seed is replaced by 1 (LFSR lock-up state)
//   step_i        : advance one position: s <= {s[W-2:0], ^(s & TAPS)}
//   msb_o         : current state MSB (the bit emitted for this position)
//   seed_match_o  : current state equals the stored seed (start of a period)
module seq_lfsr #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(8'b1011_0010)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_i,
  output logic             msb_o,
  output logic             seed_match_o
);

  localparam logic [WIDTH-1:0] RST_FIX = (RST_SEED == '0) ? WIDTH'(1) : RST_SEED;

  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] seed_fix;

  assign seed_fix = (seed_i == '0) ? WIDTH'(1) : seed_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_q    <= RST_FIX;
      seed_q <= RST_FIX;
    end else if (load_i) begin
      s_q    <= seed_fix;
      seed_q <= seed_fix;
    end else if (step_i) begin
      s_q <= {s_q[WIDTH-2:0], ^(s_q & TAPS)};
    end
  end

  assign msb_o        = s_q[WIDTH-1];
  assign seed_match_o = (s_q == seed_q);

endmodule

// File: rtl/seq_gen_param.sv
// Parametrised serial sequence generator.
// Emits a programmable pattern (1..WIDTH bits, MSB first) in loop or one-shot
// mode, or a PRBS from an LFSR, with enable/pause, runtime load and framing.
//   clk_i         : clock, all logic on rising edge
//   rst_ni        : synchronous reset, active-low (highest priority)
//   en_i          : start from IDLE / advance one bit in RUN
//   load_i        : latch pat_i/len_i/mode_i and abort to IDLE
//   mode_i        : 00 loop, 01 one-shot, 10 PRBS, 11 reserved (stays idle)
//   pat_i         : pattern (low len bits used) or LFSR seed
//   len_i         : pattern length; 0 or > WIDTH clamps to WIDTH
//   seq_o         : serial bit (registered)
//   seq_valid_o   : seq_o is a new bit this cycle
//   frame_start_o : the valid bit is the first of a period
//   done_o        : one-shot finished (sticky until load or reset)
//   dbg_state_o   : current FSM state (state_e encoding)
// Handshake: there is no back-pressure. Every edge with en_i=1 in RUN yields
// exactly one bit with seq_valid_o=1 in the following cycle; en_i=0 pauses.
module seq_gen_param
  import seq_gen_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] DEF_PAT = WIDTH'(8'b1011_0010),
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(8'hB8),
  parameter int unsigned      LW      = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] pat_i,
  input  logic [LW-1:0]    len_i,
  output logic             seq_o,
  output logic             seq_valid_o,
  output logic             frame_start_o,
  output logic             done_o,
  output logic [1:0]       dbg_state_o
);

  state_e           state_q;
  logic [WIDTH-1:0] pat_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    idx_q;   // index of the next pattern bit to emit
  logic [1:0]       mode_q;
  logic             seq_q;
  logic             valid_q;
  logic             fs_q;
  logic             done_q;

  logic [LW-1:0]    len_clamped;
  logic [LW-1:0]    last_idx;
  logic [LW-1:0]    idx_wrap;
  logic [WIDTH-1:0] pat_shift;
  logic             pat_bit;
  logic             lfsr_msb;
  logic             lfsr_match;
  logic             lfsr_step;
  logic             emit_go;
  logic             one_shot_end;

  always_comb begin
    len_clamped = len_i;
    if (len_i == '0 || len_i > LW'(WIDTH)) begin
      len_clamped = LW'(WIDTH);
    end
  end

  assign last_idx  = len_q - LW'(1);
  assign idx_wrap  = (idx_q == '0) ? last_idx : idx_q - LW'(1);
  assign pat_shift = pat_q >> idx_q;
  assign pat_bit   = pat_shift[0];

  // idx_q sits at last_idx whenever the FSM is idle, so in RUN a one-shot
  // pattern is exhausted exactly when the index has wrapped back to last_idx.
  assign one_shot_end = (mode_q == MODE_ONE) && (idx_q == last_idx);

  // A new bit is produced on this edge (start from IDLE or step in RUN).
  assign emit_go = rst_ni && !load_i && en_i &&
                   (((state_q == ST_IDLE) && (mode_q != MODE_RSV)) ||
                    ((state_q == ST_RUN) && !one_shot_end));

  assign lfsr_step = emit_go && (mode_q == MODE_PRBS);

  seq_lfsr #(
    .WIDTH    (WIDTH),
    .TAPS     (TAPS),
    .RST_SEED (DEF_PAT)
  ) u_lfsr (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (load_i),
    .seed_i       (pat_i),
    .step_i       (lfsr_step),
    .msb_o        (lfsr_msb),
    .seed_match_o (lfsr_match)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pat_q   <= DEF_PAT;
      len_q   <= LW'(WIDTH);
      idx_q   <= LW'(WIDTH - 1);
      mode_q  <= MODE_LOOP;
      seq_q   <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (load_i) begin
      state_q <= ST_IDLE;
      pat_q   <= pat_i;
      len_q   <= len_clamped;
      idx_q   <= len_clamped - LW'(1);
      mode_q  <= mode_i;
      seq_q   <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          seq_q   <= 1'b0;
          valid_q <= 1'b0;
          fs_q    <= 1'b0;
          if (emit_go) state_q <= ST_RUN;
        end
        ST_RUN: begin
          // Paused or finishing: seq_q holds unless the one-shot ends.
          valid_q <= 1'b0;
          fs_q    <= 1'b0;
          if (en_i && one_shot_end) begin
            state_q <= ST_FIN;
            seq_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_FIN: begin
          seq_q   <= 1'b0;
          valid_q <= 1'b0;
          fs_q    <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
      // Bit emission overrides the per-state defaults above.
      if (emit_go) begin
        valid_q <= 1'b1;
        if (mode_q == MODE_PRBS) begin
          seq_q <= lfsr_msb;
          fs_q  <= lfsr_match;
        end else begin
          seq_q <= pat_bit;
          fs_q  <= (idx_q == last_idx);
          idx_q <= idx_wrap;
        end
      end
    end
  end

  assign seq_o         = seq_q;
  assign seq_valid_o   = valid_q;
  assign frame_start_o = fs_q;
  assign done_o        = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_seq_gen_param.sv
module tb_seq_gen_param;

  localparam int WIDTH = 8;
  localparam int LW    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             en;
  logic             load;
  logic [1:0]       mode;
  logic [WIDTH-1:0] pat;
  logic [LW-1:0]    len;
  logic             seq;
  logic             seq_valid;
  logic             frame_start;
  logic             done;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  seq_gen_param dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .load_i        (load),
    .mode_i        (mode),
    .pat_i         (pat),
    .len_i         (len),
    .seq_o         (seq),
    .seq_valid_o   (seq_valid),
    .frame_start_o (frame_start),
    .done_o        (done),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- reference model ----------------
  // Tracks how many bits have been emitted since the last start and derives
  // each bit from the pattern / precomputed PRBS table by modulo arithmetic.
  logic [7:0] m_pat;
  int         m_len;
  int         m_mode;
  bit         m_run;
  bit         m_done;
  int         m_n;
  logic [7:0] m_seed;
  int         m_period;
  logic [7:0] m_tab [0:255];
  logic       e_seq, e_valid, e_fs, e_done;

  function automatic logic [7:0] prbs_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic build_prbs();
    logic [7:0] s;
    s = m_seed;
    m_period = 0;
    do begin
      m_tab[m_period] = s;
      m_period++;
      s = prbs_next(s);
    end while (s != m_seed && m_period < 256);
  endtask

  task automatic model_emit();
    int k;
    if (m_mode == 2) begin
      k     = m_n % m_period;
      e_seq = m_tab[k][7];
      e_fs  = (k == 0);
    end else begin
      k     = m_n % m_len;
      e_seq = m_pat[m_len - 1 - k];
      e_fs  = (k == 0);
    end
    e_valid = 1'b1;
    m_n++;
  endtask

  task automatic model_zero();
    e_seq = 0; e_valid = 0; e_fs = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_pat = 8'hB2; m_len = 8; m_mode = 0; m_run = 0; m_n = 0; m_done = 0;
      model_zero(); e_done = 0;
    end else if (load) begin
      m_pat  = pat;
      m_len  = (len == 0 || len > 8) ? 8 : int'(len);
      m_mode = int'(mode);
      m_run = 0; m_n = 0; m_done = 0;
      m_seed = (pat == 0) ? 8'd1 : pat;
      build_prbs();
      model_zero(); e_done = 0;
    end else if (m_done) begin
      model_zero(); e_done = 1;
    end else if (m_mode == 3) begin
      model_zero();
    end else if (!m_run) begin
      if (en) begin
        m_run = 1;
        model_emit();
      end else begin
        model_zero();
      end
    end else if (en) begin
      if (m_mode == 1 && m_n == m_len) begin
        m_done = 1;
        model_zero(); e_done = 1;
      end else begin
        model_emit();
      end
    end else begin
      e_valid = 0; e_fs = 0;  // pause: bit held
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] md, input logic [7:0] p, input logic [3:0] l);
    load = 1; mode = md; pat = p; len = l; en = 0;
    tick();
    load = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; en = 1; load = 0; mode = 0; pat = 0; len = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({seq, seq_valid, frame_start, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset cyc %0d got %b exp 0000 st %0d", i, {seq, seq_valid, frame_start, done}, dbg_state);
      end
    end
  endtask

  task automatic test_default_loop();
    logic [7:0] ref_pat;
    ref_pat = 8'b1011_0010;
    rst_n = 1; en = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({seq, seq_valid, frame_start, done} !==
          {ref_pat[7 - (i % 8)], 1'b1, (i == 0 || i == 8 || i == 16), 1'b0}) begin
        errors++;
        $display("FAIL default_loop bit %0d got %b exp seq=%b fs=%0d", i + 1,
                 {seq, seq_valid, frame_start, done}, ref_pat[7 - (i % 8)], (i % 8) == 0);
      end
    end
  endtask

  task automatic test_loop_len();
    logic [2:0] ref3;
    ref3 = 3'b110;
    do_load(2'b00, 8'h06, 4'd3);
    checks++;
    if ({seq, seq_valid, frame_start, done} !== 4'b0000) begin
      errors++;
      $display("FAIL loop_len_load got %b exp 0000", {seq, seq_valid, frame_start, done});
    end
    en = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if ({seq, seq_valid, frame_start} !== {ref3[2 - (i % 3)], 1'b1, (i % 3) == 0}) begin
        errors++;
        $display("FAIL loop_len3 bit %0d got %b exp seq=%b", i, {seq, seq_valid, frame_start}, ref3[2 - (i % 3)]);
      end
    end
    // len 0 clamps to 8, then an out-of-range length, then length 1
    for (int t = 0; t < 3; t++) begin
      do_load(2'b00, 8'($urandom), (t == 0) ? 4'd0 : (t == 1) ? 4'd13 : 4'd1);
      en = 1;
      for (int i = 0; i < 18; i++) begin
        tick();
        checks++;
        if ({seq, seq_valid, frame_start, done} !== {e_seq, e_valid, e_fs, e_done}) begin
          errors++;
          $display("FAIL loop_len_var t%0d bit %0d got %b exp %b", t, i,
                   {seq, seq_valid, frame_start, done}, {e_seq, e_valid, e_fs, e_done});
        end
      end
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] ref4;
    ref4 = 4'b1001;
    do_load(2'b01, 8'h09, 4'd4);
    en = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (i < 4) begin
        if ({seq, seq_valid, frame_start, done} !== {ref4[3 - i], 1'b1, i == 0, 1'b0}) begin
          errors++;
          $display("FAIL one_shot bit %0d got %b exp seq=%b", i, {seq, seq_valid, frame_start, done}, ref4[3 - i]);
        end
      end else if ({seq, seq_valid, frame_start, done} !== 4'b0001) begin
        errors++;
        $display("FAIL one_shot_done cyc %0d got %b exp 0001", i, {seq, seq_valid, frame_start, done});
      end
    end
    do_load(2'b01, 8'h09, 4'd4);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_clear got %b exp 0", done);
    end
  endtask

  task automatic test_prbs();
    logic [7:0] first8;
    int vcount;
    int last_fs;
    first8  = 8'b0000_0001;
    vcount  = 0;
    last_fs = -1;
    do_load(2'b10, 8'h00, 4'd0);
    en = 1;
    for (int i = 0; i < 560; i++) begin
      tick();
      checks++;
      if ({seq, seq_valid, frame_start, done} !== {e_seq, e_valid, e_fs, e_done}) begin
        errors++;
        $display("FAIL prbs cyc %0d got %b exp %b", i, {seq, seq_valid, frame_start, done},
                 {e_seq, e_valid, e_fs, e_done});
      end
      if (i < 8) begin
        checks++;
        if (seq !== first8[7 - i]) begin
          errors++;
          $display("FAIL prbs_first bit %0d got %b exp %b", i, seq, first8[7 - i]);
        end
      end
      if (seq_valid === 1'b1) begin
        if (frame_start === 1'b1) begin
          if (last_fs >= 0) begin
            checks++;
            if (vcount - last_fs !== 255) begin
              errors++;
              $display("FAIL prbs_period got %0d exp 255", vcount - last_fs);
            end
          end
          last_fs = vcount;
        end
        vcount++;
      end
    end
  endtask

  task automatic test_pause_and_reset();
    do_load(2'b00, 8'hB2, 4'd8);
    for (int i = 0; i < 10; i++) begin
      en = !(i >= 3 && i < 6);
      tick();
      checks++;
      if ({seq, seq_valid, frame_start, done} !== {e_seq, e_valid, e_fs, e_done}) begin
        errors++;
        $display("FAIL pause cyc %0d got %b exp %b", i, {seq, seq_valid, frame_start, done},
                 {e_seq, e_valid, e_fs, e_done});
      end
    end
    // reset mid-run after loading a different pattern
    do_load(2'b00, 8'h0F, 4'd8);
    en = 1;
    tick(); tick();
    rst_n = 0;
    tick();
    checks++;
    if ({seq, seq_valid, frame_start, done} !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_reset got %b exp 0000", {seq, seq_valid, frame_start, done});
    end
    rst_n = 1;
    tick();
    checks++;
    if ({seq, seq_valid, frame_start} !== 3'b111) begin
      errors++;
      $display("FAIL def_pat_restored got %b exp 111", {seq, seq_valid, frame_start});
    end
    tick();
    checks++;
    if ({seq, seq_valid, frame_start} !== 3'b010) begin
      errors++;
      $display("FAIL def_pat_bit2 got %b exp 010", {seq, seq_valid, frame_start});
    end
  endtask

  task automatic test_load_priority();
    en = 1;
    tick();
    load = 1; mode = 2'b00; pat = 8'hFF; len = 4'd8; en = 1;
    tick();
    load = 0;
    checks++;
    if ({seq, seq_valid, frame_start, done} !== 4'b0000) begin
      errors++;
      $display("FAIL load_over_en got %b exp 0000", {seq, seq_valid, frame_start, done});
    end
    do_load(2'b11, 8'($urandom), 4'($urandom));
    en = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({seq, seq_valid, frame_start, done} !== 4'b0000) begin
        errors++;
        $display("FAIL mode_rsv cyc %0d got %b exp 0000", i, {seq, seq_valid, frame_start, done});
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      r     = $urandom_range(0, 99);
      rst_n = (r >= 2);
      load  = (r >= 2 && r < 6);
      mode  = 2'($urandom_range(0, 3));
      pat   = 8'($urandom);
      len   = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if ({seq, seq_valid, frame_start, done} !== {e_seq, e_valid, e_fs, e_done}) begin
        errors++;
        $display("FAIL random cyc %0d mode %0d got %b exp %b", i, m_mode,
                 {seq, seq_valid, frame_start, done}, {e_seq, e_valid, e_fs, e_done});
      end
    end
    rst_n = 1; load = 0; en = 0;
  endtask

  initial begin
    rst_n = 0; en = 0; load = 0; mode = 0; pat = 0; len = 0;
    #2;
    test_reset();
    test_default_loop();
    test_loop_len();
    test_one_shot();
    test_prbs();
    test_pause_and_reset();
    test_load_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
